// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory.
// Data requests normally win; after DATA_STREAK_MAX data grants issued while
// fetch was waiting, fetch wins once. One transaction is in flight at a time.
//
// Handshake: a requester holds req and its fields until it sees a one-cycle
// gnt (only issued in IDLE). The request fields are then copied into the mem_*
// registers. mem_req stays high with stable fields until mem_ack. mem_rdata is
// valid in the same cycle as mem_ack. The owner's rvalid pulses the following
// cycle with the captured data; writes return 0.
module mem_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  localparam int SW = ($clog2(DATA_STREAK_MAX + 1) > 3) ? $clog2(DATA_STREAK_MAX + 1) : 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state,
  output logic [SW-1:0] dbg_streak
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_if_rvalid;
  logic [31:0]   r_if_rdata;
  logic          r_dm_rvalid;
  logic [31:0]   r_dm_rdata;

  logic          w_fetch_wins;
  logic          w_if_gnt;
  logic          w_dm_gnt;

  // Fetch wins when it is alone or when data has used up its streak allowance.
  assign w_fetch_wins = if_req && (!dm_req || (r_streak == STREAK_MAX));

  // Grant decision: only in IDLE, at most one, suppressed while in reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (!rst && (r_state == IDLE)) begin
      if (w_fetch_wins) begin
        w_if_gnt = 1'b1;
      end else if (dm_req) begin
        w_dm_gnt = 1'b1;
      end
    end
  end

  // Arbiter FSM: latch the granted request, wait for mem_ack, post the completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= 32'h0;
    end else begin
      // Completion pulses last exactly one cycle.
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= 32'h0;
      case (r_state)
        IDLE: begin
          // mem_ack is ignored here; nothing is outstanding.
          if (w_if_gnt) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'hF;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= 32'h0;
            r_streak    <= '0;
            r_state     <= BUSY_IF;
          end else if (w_dm_gnt) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_be    <= dm_be;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            // Only data grants that make fetch wait count toward the streak.
            if (if_req && (r_streak != STREAK_MAX)) begin
              r_streak <= r_streak + 1'b1;
            end
            r_state     <= BUSY_DM;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= mem_rdata;
            r_state     <= IDLE;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_dm_rvalid <= 1'b1;
            r_dm_rdata  <= r_mem_we ? 32'h0 : mem_rdata;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt     = w_if_gnt;
  assign dm_gnt     = w_dm_gnt;
  assign if_rvalid  = r_if_rvalid;
  assign if_rdata   = r_if_rdata;
  assign dm_rvalid  = r_dm_rvalid;
  assign dm_rdata   = r_dm_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;
  assign dbg_streak = r_streak;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-configurable memory model, a completion
// scoreboard per requester, and one task per scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_streak;

  int checks = 0;
  int errors = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];

  int          mem_lat    = 0;
  bit          mem_manual = 1'b0;
  logic [31:0] mem_data   = 32'h0;
  int          wait_cnt   = 0;

  mem_arbiter #(.DATA_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Acks mem_lat cycles after mem_req first appears (0 = same cycle).
  always @(negedge clk) begin
    if (!mem_manual) begin
      if (mem_req) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_data;
          wait_cnt  = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (if_rvalid && dm_rvalid) begin
        checks++; errors++;
        $display("FAIL rvalid_exclusive: if_rvalid=1 dm_rvalid=1, expected at most one");
      end
      if (if_rvalid) begin
        checks++;
        if (if_exp_q.size() == 0) begin
          errors++;
          $display("FAIL if_unexpected_rvalid: if_rdata=%h with nothing expected", if_rdata);
        end else begin
          e = if_exp_q.pop_front();
          if (if_rdata !== e) begin
            errors++;
            $display("FAIL if_rdata: got %h expected %h", if_rdata, e);
          end
        end
      end
      if (dm_rvalid) begin
        checks++;
        if (dm_exp_q.size() == 0) begin
          errors++;
          $display("FAIL dm_unexpected_rvalid: dm_rdata=%h with nothing expected", dm_rdata);
        end else begin
          e = dm_exp_q.pop_front();
          if (dm_rdata !== e) begin
            errors++;
            $display("FAIL dm_rdata: got %h expected %h", dm_rdata, e);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_manual = 1'b0;
    rst = 1'b1;
    clear_inputs();
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we} !== 6'b0 ||
        if_rdata !== 32'h0 || dm_rdata !== 32'h0 || mem_be !== 4'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b mem_req=%b we=%b be=%h addr=%h wdata=%h, expected all 0",
               if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if (dbg_state !== 2'd0 || dbg_streak !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d streak=%0d, expected 0 0", dbg_state, dbg_streak);
    end
    step();
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    mem_lat = 2; mem_data = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: if_gnt=%b dm_gnt=%b, expected 1 0", if_gnt, dm_gnt);
    end
    if_exp_q.push_back(32'hDEADBEEF);
    step();
    if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'hF || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL fetch_mem_c%0d: req=%b addr=%h be=%h we=%b, expected 1 00000100 f 0",
                 c, mem_req, mem_addr, mem_be, mem_we);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_rvalid_c4: rvalid=%b rdata=%h, expected 1 deadbeef", if_rvalid, if_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL fetch_idle_fields: req=%b addr=%h be=%h state=%0d, expected 0 0 0 0",
               mem_req, mem_addr, mem_be, dbg_state);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    int  rv_cyc = -1;
    int  g_cyc  = -1;
    mem_lat = 1; mem_data = 32'h2222_0200;
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL simul_first_gnt: dm_gnt=%b if_gnt=%b, expected 1 0", dm_gnt, if_gnt);
    end
    dm_exp_q.push_back(32'h2222_0200);
    step();
    dm_req = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (dbg_streak !== 3'd1) begin
          errors++;
          $display("FAIL simul_streak_inc: streak=%0d, expected 1", dbg_streak);
        end
      end
      if (dm_rvalid) rv_cyc = c;
      if (if_gnt) begin
        g_cyc = c;
        if_exp_q.push_back(32'h2222_0200);
      end
      step();
      if (g_cyc >= 0) begin
        if_req = 1'b0;
        break;
      end
    end
    checks++;
    if (g_cyc < 0 || g_cyc != rv_cyc) begin
      errors++;
      $display("FAIL simul_if_gnt_cycle: if_gnt at %0d dm_rvalid at %0d, expected equal and present",
               g_cyc, rv_cyc);
    end
    @(negedge clk);
    checks++;
    if (dbg_streak !== 3'd0) begin
      errors++;
      $display("FAIL simul_streak_clear: streak=%0d, expected 0", dbg_streak);
    end
    drain();
  endtask

  task automatic test_starvation();
    int n   = 0;
    int cyc = 0;
    bit exp_if;
    mem_lat = 0; mem_data = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500;
    while (n < 15 && cyc < 200) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        exp_if = (n % 5 == 4);
        checks++;
        if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin
          errors++;
          $display("FAIL starve_grant_%0d: if_gnt=%b dm_gnt=%b, expected if_gnt=%b dm_gnt=%b",
                   n, if_gnt, dm_gnt, exp_if, !exp_if);
        end
        if (if_gnt) if_exp_q.push_back(mem_data);
        if (dm_gnt) dm_exp_q.push_back(mem_data);
        n++;
      end
      cyc++;
      step();
    end
    checks++;
    if (n < 15) begin
      errors++;
      $display("FAIL starve_timeout: saw %0d grants, expected 15", n);
    end
    clear_inputs();
    drain();
  endtask

  task automatic test_write();
    mem_lat = 3; mem_data = 32'hCAFE_F00D;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'h1234;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1) begin
      errors++;
      $display("FAIL write_gnt: dm_gnt=%b, expected 1", dm_gnt);
    end
    dm_exp_q.push_back(32'h0);
    step();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
          mem_addr !== 32'h300 || mem_wdata !== 32'h1234) begin
        errors++;
        $display("FAIL write_mem_c%0d: req=%b we=%b be=%h addr=%h wdata=%h, expected 1 1 3 300 1234",
                 c, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_complete: dm_rvalid=%b dm_rdata=%h if_rvalid=%b, expected 1 0 0",
               dm_rvalid, dm_rdata, if_rvalid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mem_manual = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h700;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h800;
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || dbg_streak !== 3'd1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: state=%0d streak=%0d mem_req=%b, expected 2 1 1",
               dbg_state, dbg_streak, mem_req);
    end
    step();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || dm_rvalid !== 1'b0 || dbg_state !== 2'd0 || dbg_streak !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after: mem_req=%b dm_rvalid=%b state=%0d streak=%0d, expected 0 0 0 0",
               mem_req, dm_rvalid, dbg_state, dbg_streak);
    end
    mem_manual = 1'b0;
    drain();
  endtask

  task automatic test_idle_ack();
    mem_manual = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || dbg_state !== 2'd0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack_c%0d: rvalid=%b%b state=%0d mem_req=%b, expected 0 0 0 0",
                 c, if_rvalid, dm_rvalid, dbg_state, mem_req);
      end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    mem_manual = 1'b0;
    drain();
  endtask

  task automatic test_dropped_request();
    bit saw_if_gnt = 1'b0;
    mem_lat = 3; mem_data = 32'h6666_0600;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h600;
    @(negedge clk);
    if (dm_gnt) dm_exp_q.push_back(32'h6666_0600);
    step();
    clear_inputs();
    if_req = 1'b1; if_addr = 32'h900;
    step();
    if_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_gnt) saw_if_gnt = 1'b1;
      step();
    end
    checks++;
    if (saw_if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL dropped_if_gnt: if_gnt seen=%b, expected 0", saw_if_gnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_reset_mid();
    test_idle_ack();
    test_dropped_request();
    drain();
    checks++;
    if (if_exp_q.size() != 0 || dm_exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_completions: if=%0d dm=%0d outstanding, expected 0 0",
               if_exp_q.size(), dm_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_STREAK_MAX, default 4, meaning the number of consecutive data grants allowed while fetch waits, after which fetch wins once.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  one-cycle acceptance of the fetch request.
- if_rvalid  out  1  one-cycle fetch data valid.
- if_rdata  out  32  fetch data, valid with if_rvalid.
- dm_req  in  1  data-memory request; held with dm_* fields until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_be  in  4  byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  write data.
- dm_gnt  out  1  one-cycle acceptance of the data request.
- dm_rvalid  out  1  one-cycle completion pulse, for reads and writes.
- dm_rdata  out  32  read data, valid with dm_rvalid; 0 on write completion.
- mem_req  out  1  request to the shared single-port memory.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  registered request fields.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read data.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-004 SHALL assert if_gnt/dm_gnt only in IDLE, combinationally, at most one per cycle.
REQ-005 SHALL latch the granted request's fields into the mem_* registers on the grant edge, then enter BUSY_IF or BUSY_DM.
REQ-006 For fetch grants, SHALL drive mem_we=0 and mem_be=4'b1111.
REQ-007 In BUSY_*, SHALL hold mem_req=1 and all mem_* fields stable until mem_ack.
REQ-008 On mem_ack in BUSY_*, SHALL return to IDLE and register the completion.
REQ-009 In the cycle after mem_ack, SHALL pulse the owner's rvalid for one cycle with rdata = captured mem_rdata (0 for writes).
REQ-010 A new grant MAY occur in the same cycle as the rvalid pulse; minimum transaction spacing is 2 cycles plus memory latency.
REQ-011 In IDLE with mem_req=0, SHALL drive the mem_* fields to 0.
REQ-012 SHALL ignore mem_ack while in IDLE.
REQ-013 Priority: dm_req SHALL win over if_req, unless streak==DATA_STREAK_MAX and if_req=1, in which case fetch SHALL win.
REQ-014 SHALL increment a 3-bit-minimum streak counter on each dm grant issued while if_req=1, saturating at DATA_STREAK_MAX.
REQ-015 SHALL clear the streak counter on every fetch grant; it is unchanged by a dm grant when if_req=0.
REQ-016 SHALL keep if_rvalid and dm_rvalid mutually exclusive and asserted only for the owning requester.
REQ-017 SHALL leave requests that drop before being granted without effect and raise no error.

Reset
REQ-018 On rst, SHALL set state=IDLE, streak=0, and all outputs to 0, including mem_req, gnts, rvalids and rdatas.
REQ-019 rst asserted during BUSY_* SHALL abandon the transaction: mem_req low next cycle and no rvalid pulse for it; rst has priority over simultaneous mem_ack.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> if_gnt pulse at cycle 0; mem_req cycles 1-3 with addr 0x100 and be 1111; if_rvalid=1 and if_rdata=0xDEADBEEF at cycle 4.
REQ-021 Simultaneous requests: if_req and dm_req (read 0x200) both rise in cycle 0 -> dm_gnt first; if_gnt in the cycle dm_rvalid pulses.
REQ-022 Starvation: if_req and dm_req held high continuously, mem_ack immediate -> grant pattern DM,DM,DM,DM,IF repeating.
REQ-023 Write completion: dm_we=1, be=0011, wdata=0x1234, addr=0x300 -> mem_we=1 and mem_be=0011 held until ack; dm_rvalid pulse with dm_rdata=0; if_rvalid stays 0.
REQ-024 Reset mid-transaction: rst asserted in a BUSY_DM cycle together with mem_ack -> next cycle mem_req=0, dm_rvalid=0, state IDLE, streak 0.
REQ-025 Idle ack: mem_ack pulsed in IDLE with no requests -> no rvalid and no state change.
